sap_prom16_8bit: RTL and testbench



---
 rtl/sap_prom16_8bit.sv | 72 +++++++
 tb/tb_sap_prom16_8bit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sap_prom16_8bit.sv
// sap_prom16_8bit: 16 x 8 writable program/data memory for a SAP-style CPU.
//
// Storage is a bank of registers. The bank is cleared asynchronously by
// low_clr. A word is written on the rising clk edge while low_load is low,
// and it is read combinationally onto data_out while low_o_en is low.
//
// Bus protocol: this block has no valid/ready handshake. The CPU controller
// owns the timing. A write happens on the first rising edge on which
// low_load=0 and low_clr=1. A read is valid in the same cycle in which
// low_o_en=0 and addr is stable. There is no back-pressure and no latency.
//
// Build option: PROM_TRISTATE_EN.
//   Undefined (default): a disabled output drives 0, for OR-mux bus merging.
//   Defined: a disabled output drives Z, so the block can sit on the W-bus
//   directly.
//   Storage, write timing and read timing are the same in both builds.
module sap_prom16_8bit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              low_clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              low_o_en,
  input  logic              low_load,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  word_sel;
  logic [DATA_W-1:0] read_word;

  // One-hot write decode. If addr is unknown in simulation, every select is
  // unknown. The if() below then treats each select as false, so no word is
  // corrupted.
  for (genvar g = 0; g < DEPTH; g++) begin : g_sel
    assign word_sel[g] = (addr == ADDR_W'(g)) & ~low_load;
  end

  // Storage: async clear of every word; otherwise at most one word loads data_in.
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_sel[i]) begin
          mem[i] <= data_in;
        end
      end
    end
  end

  // Combinational read port. Clear forces the bank to zero, so data_out
  // follows to zero asynchronously while the output is enabled.
  always_comb begin
    read_word = mem[addr];
  end

`ifdef PROM_TRISTATE_EN
  // Output stage: drive the bus when enabled, release it (Z) when disabled.
  assign data_out = low_o_en ? {DATA_W{1'bz}} : read_word;
`else
  // Output stage: drive the bus when enabled, drive zero when disabled.
  assign data_out = low_o_en ? '0 : read_word;
`endif

endmodule

// File: tb/tb_sap_prom16_8bit.sv
// Self-checking bench for sap_prom16_8bit.
// Stimulus tasks push the expected value into exp_q and then raise a sample
// event. A separate monitor pops each entry and compares it against data_out.
// Expected values come from a plain array model of the memory.
module tb_sap_prom16_8bit;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              low_clr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic              low_o_en;
  logic              low_load;
  logic [DATA_W-1:0] data_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sap_prom16_8bit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .low_clr  (low_clr),
    .data_in  (data_in),
    .addr     (addr),
    .low_o_en (low_o_en),
    .low_load (low_load),
    .data_out (data_out)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] model_mem [DEPTH];

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a,
                                                   input logic oe_n);
    logic [DATA_W-1:0] v;
    if (oe_n) begin
`ifdef PROM_TRISTATE_EN
      v = {DATA_W{1'bz}};
`else
      v = '0;
`endif
    end else begin
      v = model_mem[a];
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  string             name_q[$];
  int                n_checks;
  int                n_pass;
  event              sample_ev;

  initial begin
    n_checks = 0;
    n_pass   = 0;
  end

  // Monitor: pops one expectation per sample request and compares.
  initial begin
    logic [DATA_W-1:0] e;
    string nm;
    forever begin
      @(sample_ev);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (data_out === e) n_pass++;
        else $display("FAIL %s: addr=%0d data_out=%h expected=%h", nm, addr, data_out, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Queue the model's expected output for the current addr/low_o_en and
  // request a sample. Inputs are given 1 ns to settle before the request.
  task automatic expect_out(input string nm, input logic [DATA_W-1:0] e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  task automatic read_check(input string nm, input logic [ADDR_W-1:0] a,
                            input logic oe_n);
    addr     = a;
    low_o_en = oe_n;
    expect_out(nm, model_read(a, oe_n));
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    addr     = a;
    data_in  = d;
    low_load = 1'b0;
    @(negedge clk);
    low_load = 1'b1;
    if (low_clr) model_mem[a] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              roe;

    low_clr  = 1'b0;
    low_load = 1'b1;
    low_o_en = 1'b0;
    addr     = '0;
    data_in  = '0;
    model_clear();
    #10;
    low_clr = 1'b1;
    @(negedge clk);

    // Reset sweep.
    for (int i = 0; i < DEPTH; i++) read_check("reset_sweep", ADDR_W'(i), 1'b0);

    // Fill with 0x11, then read it back.
    for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), 8'h11);
    for (int i = 0; i < DEPTH; i++) read_check("fill_read", ADDR_W'(i), 1'b0);

    // Distinct pattern i*0x11, read back in reverse order.
    for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), DATA_W'(i * 8'h11));
    for (int i = DEPTH - 1; i >= 0; i--) read_check("distinct_rev", ADDR_W'(i), 1'b0);

    // Output disable, then enable without any clock edge in between.
    write_word(4'd5, 8'hA5);
    @(negedge clk);
    read_check("oe_disabled", 4'd5, 1'b1);
    read_check("oe_enabled", 4'd5, 1'b0);

    // Simultaneous load and read.
    write_word(4'd3, 8'h3C);
    @(negedge clk);
    addr     = 4'd3;
    low_o_en = 1'b0;
    data_in  = 8'hC3;
    low_load = 1'b0;
    expect_out("sim_before_edge", 8'h3C);
    @(posedge clk);
    model_mem[3] = 8'hC3;
    expect_out("sim_after_edge", 8'hC3);
    low_load = 1'b1;
    read_check("sim_neighbor", 4'd4, 1'b0);

    // Randomized writes and reads.
    for (int n = 0; n < 300; n++) begin
      ra = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        rd = DATA_W'($urandom);
        write_word(ra, rd);
      end else begin
        @(negedge clk);
        roe = ($urandom_range(0, 3) == 0);
        read_check("random_read", ra, roe);
      end
    end

    // Mid-operation reset, asserted between edges with a write pending.
    for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), 8'h5A);
    @(negedge clk);
    addr     = 4'd2;
    low_o_en = 1'b0;
    data_in  = 8'h77;
    low_load = 1'b0;
    #2;
    low_clr = 1'b0;
    model_clear();
    expect_out("clr_immediate", 8'h00);
    read_check("clr_oe_off", 4'd2, 1'b1);
    low_o_en = 1'b0;
    @(posedge clk);
    expect_out("clr_edge_no_write", 8'h00);
    @(negedge clk);
    low_load = 1'b1;
    low_clr  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) read_check("post_clr_sweep", ADDR_W'(i), 1'b0);

    // Normal writes resume after the clear is released.
    write_word(4'd9, 8'h9E);
    @(negedge clk);
    read_check("post_clr_write", 4'd9, 1'b0);
    read_check("post_clr_other", 4'd8, 1'b0);

    // Every queued expectation must have been consumed by the monitor.
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: leftover=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
